// File: rtl/cr_rbus_initiator_if.sv
// rtl/cr_rbus_initiator_if.sv - rbus ring record type and host request/response interface
//
// Contents:
//   N_RBUS_ADDR_BITS      register byte address width (default 16 unless predefined)
//   cr_rbus_pkg           rbus_ring_t: one ring beat as seen by every regfile
//   cr_rbus_initiator_if  host-side command/response bundle
//     host_req_vld/rdy    command handshake (rdy driven by initiator)
//     host_req_wr         1=write, 0=read
//     host_req_addr       register byte address
//     host_req_wdata      write data
//     host_rsp_vld/rdy    response handshake (vld driven by initiator)
//     host_rsp_rdata      read data, 0 for writes and timeouts
//     host_rsp_err        slave answered with err_ack
//     host_rsp_timeout    nothing came back in time
//   modport master = host side, modport slave = initiator side

`ifndef N_RBUS_ADDR_BITS
`define N_RBUS_ADDR_BITS 16
`endif

package cr_rbus_pkg;
  typedef struct packed {
    logic [`N_RBUS_ADDR_BITS-1:0] addr;
    logic                         wr_strb;
    logic                         rd_strb;
    logic [31:0]                  wr_data;
    logic                         ack;
    logic                         err_ack;
    logic [31:0]                  rd_data;
  } rbus_ring_t;
endpackage

interface cr_rbus_initiator_if;
  logic                         host_req_vld;
  logic                         host_req_rdy;
  logic                         host_req_wr;
  logic [`N_RBUS_ADDR_BITS-1:0] host_req_addr;
  logic [31:0]                  host_req_wdata;
  logic                         host_rsp_vld;
  logic                         host_rsp_rdy;
  logic [31:0]                  host_rsp_rdata;
  logic                         host_rsp_err;
  logic                         host_rsp_timeout;

  modport master (
    output host_req_vld, host_req_wr, host_req_addr, host_req_wdata, host_rsp_rdy,
    input  host_req_rdy, host_rsp_vld, host_rsp_rdata, host_rsp_err, host_rsp_timeout
  );

  modport slave (
    input  host_req_vld, host_req_wr, host_req_addr, host_req_wdata, host_rsp_rdy,
    output host_req_rdy, host_rsp_vld, host_rsp_rdata, host_rsp_err, host_rsp_timeout
  );
endinterface

// File: rtl/cr_rbus_initiator.sv
// rtl/cr_rbus_initiator.sv - rbus register-ring master: issues one host command, waits for its return
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   host           cr_rbus_initiator_if.slave: host command/response handshake
//   rbus_ring_o    ring beat driven to the first regfile
//   rbus_ring_i    ring beat returning from the last regfile (terminated here)
//   stat_txn_cnt   completed host responses (wrapping)
//   stat_to_cnt    timeouts (saturating)
//
// Optional feature macro: CR_RBUS_INITIATOR_STATS_EN
//   defined   -> stat counters implemented
//   undefined -> stat ports tied to 0
//
// Flow: IDLE -> ISSUE (strobe on ring for one cycle) -> WAIT (until own addr
// returns with ack/err_ack, or timeout) -> RSP (hold until host takes it).
// All host and ring outputs are registered.

module cr_rbus_initiator
  import cr_rbus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cr_rbus_initiator_if.slave   host,
  output rbus_ring_t           rbus_ring_o,
  input  rbus_ring_t           rbus_ring_i,
  output logic [31:0]          stat_txn_cnt,
  output logic [15:0]          stat_to_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RSP   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Holding registers for the accepted command
  logic                         wr_q;
  logic [`N_RBUS_ADDR_BITS-1:0] addr_q;

  logic                req_rdy_q;
  logic                rsp_vld_q;
  logic [31:0]         rsp_rdata_q;
  logic                rsp_err_q;
  logic                rsp_to_q;
  rbus_ring_t          ring_q;
  logic [TO_CNT_W-1:0] to_cnt_q;

  logic req_fire;
  logic rsp_fire;
  logic hit;
  logic limit;
  logic done;
  logic to_fire;

  // The ring ends here; only addr/ack/err_ack/rd_data of the returning beat
  // matter, the rest is deliberately dropped.
  logic ring_i_unused;
  assign ring_i_unused = ^{rbus_ring_i.wr_strb, rbus_ring_i.rd_strb, rbus_ring_i.wr_data};

  assign req_fire = (state_q == IDLE) && host.host_req_vld && req_rdy_q;
  assign rsp_fire = (state_q == RSP) && host.host_rsp_rdy && rsp_vld_q;

  // Only our own address coming back with an ack closes the transaction;
  // acks for other addresses are ignored.
  assign hit   = (rbus_ring_i.addr == addr_q) && (rbus_ring_i.ack || rbus_ring_i.err_ack);
  assign limit = (to_cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1));
  assign done    = (state_q == WAIT) && hit;
  // Completion on the limit cycle wins over the timeout.
  assign to_fire = (state_q == WAIT) && !hit && limit;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (req_fire) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (done || to_fire) state_d = RSP;
      RSP:   if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command capture and host request ready
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_rdy_q <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
    end else begin
      // Registered ready: drops the cycle after acceptance, rises when the
      // response is taken.
      req_rdy_q <= (state_d == IDLE);
      if (req_fire) begin
        wr_q   <= host.host_req_wr;
        addr_q <= host.host_req_addr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Ring output: strobes and write data during ISSUE only, address held
  // through WAIT, everything 0 otherwise.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring_q <= '0;
    end else if (req_fire) begin
      ring_q         <= '0;
      ring_q.addr    <= host.host_req_addr;
      ring_q.wr_strb <= host.host_req_wr;
      ring_q.rd_strb <= ~host.host_req_wr;
      ring_q.wr_data <= host.host_req_wr ? host.host_req_wdata : 32'h0;
    end else if (state_d == WAIT) begin
      ring_q      <= '0;
      ring_q.addr <= addr_q;
    end else begin
      ring_q <= '0;
    end
  end

  assign rbus_ring_o = ring_q;

  // ---------------------------------------------------------------------------
  // Timeout counter: cleared while issuing, counts every WAIT cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      to_cnt_q <= '0;
    end else if (state_q == WAIT) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Response registers: held stable in RSP until the host handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else if (done) begin
      rsp_vld_q   <= 1'b1;
      rsp_rdata_q <= wr_q ? 32'h0 : rbus_ring_i.rd_data;
      rsp_err_q   <= rbus_ring_i.err_ack;
      rsp_to_q    <= 1'b0;
    end else if (to_fire) begin
      rsp_vld_q   <= 1'b1;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b1;
    end else if (rsp_fire) begin
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end
  end

  assign host.host_req_rdy     = req_rdy_q;
  assign host.host_rsp_vld     = rsp_vld_q;
  assign host.host_rsp_rdata   = rsp_rdata_q;
  assign host.host_rsp_err     = rsp_err_q;
  assign host.host_rsp_timeout = rsp_to_q;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef CR_RBUS_INITIATOR_STATS_EN
  logic [31:0] txn_cnt_q;
  logic [15:0] to_stat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt_q <= 32'h0;
      to_stat_q <= 16'h0;
    end else begin
      // Every handshaken response counts, including errors and timeouts;
      // wraps naturally.
      if (rsp_fire) begin
        txn_cnt_q <= txn_cnt_q + 32'h1;
      end
      if (to_fire && (to_stat_q != 16'hFFFF)) begin
        to_stat_q <= to_stat_q + 16'h1;
      end
    end
  end

  assign stat_txn_cnt = txn_cnt_q;
  assign stat_to_cnt  = to_stat_q;
`else
  assign stat_txn_cnt = 32'h0;
  assign stat_to_cnt  = 16'h0;
`endif

endmodule
